// File: rtl/weight_tile_scheduler.sv
// Weight-tile fetch sequencer: streams MUL_SIZE-row tiles from weight memory
// into the weight FIFO, keeping at most two tiles in flight (active + shadow).
// Ports: clk_i/rst_i (async active-high); start_i, base_addr_i, num_tiles_i
//   job config; fifo_full_i backpressure; tile_consumed_i retire pulse;
//   mem_rd_en_o/mem_rd_addr_o memory read; fifo_push_o read delayed 1 cycle;
//   next_weight_tile_o, done_o hand-off pulses; busy_o job active.
// Optional: define WEIGHT_SCHED_PERF_EN to add stall_cycles_o[31:0].
module weight_tile_scheduler #(
  parameter int MUL_SIZE = 32,
  parameter int ADDR_W   = 16,
  parameter int TILE_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [TILE_W-1:0] num_tiles_i,
  input  logic              fifo_full_i,
  input  logic              tile_consumed_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  output logic              fifo_push_o,
  output logic              next_weight_tile_o,
  output logic              done_o,
  output logic              busy_o
`ifdef WEIGHT_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_cycles_o
`endif
);

  localparam int RW = $clog2(MUL_SIZE);

  typedef enum logic [2:0] {
    IDLE, FETCH, HOLD, DRAIN, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RW-1:0]     row_q, row_d;
  logic [TILE_W-1:0] num_q, num_d;
  logic [TILE_W-1:0] fetched_q, fetched_d;
  logic [TILE_W-1:0] retired_q, retired_d;
  logic              push_q;
  logic              ntile_q, ntile_d;

  logic              rd_en;
  logic              tile_done;
  logic              retire;
  logic [TILE_W-1:0] fetched_inc;
  logic [TILE_W-1:0] retired_inc;

  assign rd_en       = (state_q == FETCH) && !fifo_full_i;
  assign tile_done   = rd_en && (row_q == RW'(MUL_SIZE - 1));
  // Only a fully fetched, not yet retired tile can be consumed.
  assign retire      = tile_consumed_i && (retired_q < fetched_q);
  assign fetched_inc = fetched_q + TILE_W'(1);
  assign retired_inc = retired_q + TILE_W'(1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    row_d     = row_q;
    num_d     = num_q;
    fetched_d = fetched_q;
    retired_d = retired_q;
    ntile_d   = 1'b0;

    if (retire) begin
      retired_d = retired_inc;
      // Last tile gets done_o instead of a hand-off pulse.
      ntile_d   = (retired_inc < num_q);
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d    = base_addr_i;
          num_d     = num_tiles_i;
          row_d     = '0;
          fetched_d = '0;
          retired_d = '0;
          state_d   = (num_tiles_i == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        if (rd_en) begin
          addr_d = addr_q + ADDR_W'(1);
          row_d  = tile_done ? '0 : row_q + RW'(1);
        end
        if (tile_done) begin
          fetched_d = fetched_inc;
          if (fetched_inc == num_q)
            state_d = DRAIN;
          else if ((fetched_inc - retired_q) == TILE_W'(2) && !retire)
            state_d = HOLD;
        end
      end
      HOLD: begin
        if (retire)
          state_d = FETCH;
      end
      DRAIN: begin
        if (retire && retired_inc == num_q)
          state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      row_q     <= '0;
      num_q     <= '0;
      fetched_q <= '0;
      retired_q <= '0;
      push_q    <= 1'b0;
      ntile_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      row_q     <= row_d;
      num_q     <= num_d;
      fetched_q <= fetched_d;
      retired_q <= retired_d;
      push_q    <= rd_en;
      ntile_q   <= ntile_d;
    end
  end

  assign mem_rd_en_o        = rd_en;
  assign mem_rd_addr_o      = addr_q;
  assign fifo_push_o        = push_q;
  assign next_weight_tile_o = ntile_q;
  assign done_o             = (state_q == FINISH);
  assign busy_o             = (state_q != IDLE);

`ifdef WEIGHT_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_evt;

  assign stall_evt = ((state_q == FETCH) && fifo_full_i) ||
                     (state_q == HOLD);

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start_i)
      stall_d = '0;
    else if (stall_evt && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// Scoreboard bench for weight_tile_scheduler (MUL_SIZE=4).
// Driver queues expected reads/pulses; a negedge monitor pops and compares.
module tb_weight_tile_scheduler;

  localparam int MS = 4;
  localparam int AW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [TW-1:0] num = '0;
  logic          full = 1'b0;
  logic          tile = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          push;
  logic          ntile;
  logic          done;
  logic          busy;
`ifdef WEIGHT_SCHED_PERF_EN
  logic [31:0]   stall;
`endif

  weight_tile_scheduler #(
    .MUL_SIZE(MS), .ADDR_W(AW), .TILE_W(TW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .base_addr_i(base),
    .num_tiles_i(num),
    .fifo_full_i(full),
    .tile_consumed_i(tile),
    .mem_rd_en_o(rd_en),
    .mem_rd_addr_o(rd_addr),
    .fifo_push_o(push),
    .next_weight_tile_o(ntile),
    .done_o(done),
    .busy_o(busy)
`ifdef WEIGHT_SCHED_PERF_EN
    ,
    .stall_cycles_o(stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } rd_t;

  rd_t rd_q[$];
  int  nt_q[$];
  int  dn_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // Monitor
  initial begin
    logic prev_rd;
    rd_t  e;
    int   ec;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outs", {rd_en, push, ntile, done, busy, rd_addr}, '0);
        prev_rd = 1'b0;
      end else begin
        check("push_follows_read", push, prev_rd);
        prev_rd = rd_en;
        if (rd_en) begin
          check("read_expected", rd_q.size() != 0, 1);
          if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            check("rd_addr", rd_addr, e.addr);
            check("rd_cycle", cyc, e.cyc);
          end
        end
        if (ntile) begin
          check("ntile_expected", nt_q.size() != 0, 1);
          if (nt_q.size() != 0) begin
            ec = nt_q.pop_front();
            check("ntile_cycle", cyc, ec);
          end
        end
        if (done) begin
          check("done_expected", dn_q.size() != 0, 1);
          check("busy_at_done", busy, 1);
          if (dn_q.size() != 0) begin
            ec = dn_q.pop_front();
            check("done_cycle", cyc, ec);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [TW-1:0] n,
                           output int s);
    tick();
    start = 1'b1;
    base  = b;
    num   = n;
    s     = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic exp_reads(input logic [AW-1:0] b, input int cnt,
                           input int c0);
    for (int i = 0; i < cnt; i++)
      rd_q.push_back('{AW'(b + AW'(i)), c0 + i});
  endtask

  task automatic consume(input bit exp_nt, input bit exp_dn);
    tile = 1'b1;
    if (exp_nt) nt_q.push_back(cyc + 1);
    if (exp_dn) dn_q.push_back(cyc + 1);
    tick();
    tile = 1'b0;
  endtask

  task automatic drained(input string nm);
    check({nm, "_reads_left"}, rd_q.size(), 0);
    check({nm, "_ntile_left"}, nt_q.size(), 0);
    check({nm, "_done_left"}, dn_q.size(), 0);
  endtask

  initial begin
    int s;
    int c;

    tick();
    tick();
    rst = 1'b0;
    check("idle_outs", {rd_en, push, ntile, done, busy, rd_addr}, '0);

    // One tile, no backpressure
    start_job(16'h0100, 8'd1, s);
    exp_reads(16'h0100, 4, s + 1);
    check("busy_after_start", busy, 1);
    repeat (5) tick();
    consume(1'b0, 1'b1);
    tick();
    check("busy_after_done", busy, 0);
    drained("t1");

    // Three tiles: HOLD after two, then resume
    start_job(16'h0200, 8'd3, s);
    exp_reads(16'h0200, 8, s + 1);
    repeat (11) tick();
    c = cyc;
    exp_reads(16'h0208, 4, c + 1);
    consume(1'b1, 1'b0);
    repeat (5) tick();
    consume(1'b1, 1'b0);
    tick();
    consume(1'b0, 1'b1);
    repeat (2) tick();
`ifdef WEIGHT_SCHED_PERF_EN
    check("stall_hold", stall, 32'd4);
`endif
    drained("t2");

    // FIFO full for 5 cycles mid-tile
    start_job(16'h0300, 8'd1, s);
    rd_q.push_back('{16'h0300, s + 1});
    rd_q.push_back('{16'h0301, s + 2});
    rd_q.push_back('{16'h0302, s + 8});
    rd_q.push_back('{16'h0303, s + 9});
    tick();
    tick();
    full = 1'b1;
    repeat (5) tick();
    full = 1'b0;
    repeat (3) tick();
    consume(1'b0, 1'b1);
    repeat (2) tick();
`ifdef WEIGHT_SCHED_PERF_EN
    check("stall_full", stall, 32'd5);
`endif
    drained("t3");

    // Empty job, then consume in IDLE
    start_job(16'h0abc, 8'd0, s);
    dn_q.push_back(s + 1);
    tick();
    consume(1'b0, 1'b0);
    repeat (3) tick();
    check("empty_busy", busy, 0);
    drained("t4");

    // Async reset mid-FETCH of tile 1
    start_job(16'h0400, 8'd3, s);
    exp_reads(16'h0400, 5, s + 1);
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outs",
          {rd_en, push, ntile, done, busy, rd_addr}, '0);
`ifdef WEIGHT_SCHED_PERF_EN
    check("async_reset_stall", stall, 32'd0);
`endif
    tick();
    rst = 1'b0;
    drained("t5a");
    start_job(16'h0500, 8'd2, s);
    exp_reads(16'h0500, 8, s + 1);
    repeat (9) tick();
    consume(1'b1, 1'b0);
    tick();
    consume(1'b0, 1'b1);
    repeat (2) tick();
    drained("t5b");

    // Tile-completing read coincides with a retire at two in flight
    start_job(16'h0600, 8'd3, s);
    exp_reads(16'h0600, 12, s + 1);
    repeat (7) tick();
    consume(1'b1, 1'b0);
    repeat (5) tick();
    consume(1'b1, 1'b0);
    tick();
    consume(1'b0, 1'b1);
    repeat (2) tick();
    drained("t6");

    // Address wraps modulo 2^ADDR_W
    start_job(16'hfffe, 8'd1, s);
    rd_q.push_back('{16'hfffe, s + 1});
    rd_q.push_back('{16'hffff, s + 2});
    rd_q.push_back('{16'h0000, s + 3});
    rd_q.push_back('{16'h0001, s + 4});
    repeat (5) tick();
    consume(1'b0, 1'b1);
    repeat (2) tick();
    drained("t7");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
